z_to_z_calculator: RTL and testbench

Backprop stage that computes each neuron's error term (dCost/dz) from a registered activation derivative and an upstream gradient. The upstream gradient is the cost derivative for the output layer, or the gradient propagated back through the dense weights for hidden layers. The block is a vector of `size` independent signed fixed-point lanes. It sits in the backprop stack between the activation-derivative source and the weight-gradient / dense back-propagation units.

---
 rtl/backprop_pkg.sv | 40 ++++
 rtl/fxp_mul_sat.sv | 15 +
 rtl/z_to_z_calculator.sv | 51 +++++
 tb/tb_z_to_z_calculator.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/backprop_pkg.sv
// Shared fixed-point definitions for the backprop stages.
// The product is truncated toward -inf and then saturated to the lane range.
package backprop_pkg;

  localparam int DATA_SIZE = 16;
  localparam int FRAC_BITS = DATA_SIZE / 2;
  localparam int MAX_W     = 32;

  localparam logic [DATA_SIZE-1:0] SAT_MAX = {1'b0, {(DATA_SIZE-1){1'b1}}};
  localparam logic [DATA_SIZE-1:0] SAT_MIN = {1'b1, {(DATA_SIZE-1){1'b0}}};

  // Operands arrive sign-extended to MAX_W; w is the real lane width (<= MAX_W).
  // The result is saturated to the w-bit signed range and returned sign-extended.
  function automatic logic signed [MAX_W-1:0] fxmul(
    input logic signed [MAX_W-1:0] a,
    input logic signed [MAX_W-1:0] b,
    input int                      w
  );
    logic signed [2*MAX_W-1:0] a_w;
    logic signed [2*MAX_W-1:0] b_w;
    logic signed [2*MAX_W-1:0] prod;
    logic signed [2*MAX_W-1:0] shifted;
    logic signed [2*MAX_W-1:0] hi;
    logic signed [2*MAX_W-1:0] lo;
    a_w     = {{MAX_W{a[MAX_W-1]}}, a};
    b_w     = {{MAX_W{b[MAX_W-1]}}, b};
    prod    = a_w * b_w;
    shifted = prod >>> (w / 2);
    hi      = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo      = -(64'sd1 <<< (w - 1));
    if (shifted > hi) begin
      fxmul = hi[MAX_W-1:0];
    end else if (shifted < lo) begin
      fxmul = lo[MAX_W-1:0];
    end else begin
      fxmul = shifted[MAX_W-1:0];
    end
  endfunction

endpackage

// File: rtl/fxp_mul_sat.sv
// One lane of signed fixed-point multiply: full product, arithmetic shift
// by data_size/2, saturate. Purely combinational.
module fxp_mul_sat
  import backprop_pkg::*;
#(
  parameter int data_size = DATA_SIZE
) (
  input  logic [data_size-1:0] a,
  input  logic [data_size-1:0] b,
  output logic [data_size-1:0] y
);

  assign y = data_size'(fxmul(MAX_W'($signed(a)), MAX_W'($signed(b)), data_size));

endmodule

// File: rtl/z_to_z_calculator.sv
// Per-lane error term: delta = f'(z) * upstream gradient, registered.
// No valid/ready handshake: the output is valid one edge after its inputs and consumers sample by schedule.
module z_to_z_calculator
  import backprop_pkg::*;
#(
  parameter int data_size = DATA_SIZE,
  parameter int size      = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      set_diff_act,
  input  logic                      start_new_layer,
  input  logic [data_size*size-1:0] diff_act,
  input  logic [data_size*size-1:0] diff_cost,
  input  logic [data_size*size-1:0] diff_dense,
  output logic [data_size*size-1:0] diff_z_to_z
);

  localparam int W = data_size * size;

  logic [W-1:0] act_q;
  logic [W-1:0] up;
  logic [W-1:0] lane_prod;

  // Source select follows the current level of start_new_layer; nothing is latched.
  assign up = start_new_layer ? diff_cost : diff_dense;

  for (genvar i = 0; i < size; i++) begin : g_lane
    fxp_mul_sat #(
      .data_size(data_size)
    ) u_mul (
      .a(act_q[data_size*i +: data_size]),
      .b(up[data_size*i +: data_size]),
      .y(lane_prod[data_size*i +: data_size])
    );
  end

  // The product uses act_q from before the edge, so a load shows up one edge later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      act_q       <= '0;
      diff_z_to_z <= '0;
    end else begin
      if (set_diff_act) begin
        act_q <= diff_act;
      end
      diff_z_to_z <= lane_prod;
    end
  end

endmodule

// File: tb/tb_z_to_z_calculator.sv
// Randomized and directed bench for z_to_z_calculator with a scoreboard
// fed by an arithmetic reference model.
module tb_z_to_z_calculator;

  localparam int DS = 16;
  localparam int SZ = 3;
  localparam int W  = DS * SZ;

  logic         clk;
  logic         reset;
  logic         set_diff_act;
  logic         start_new_layer;
  logic [W-1:0] diff_act;
  logic [W-1:0] diff_cost;
  logic [W-1:0] diff_dense;
  logic [W-1:0] diff_z_to_z;

  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           n_checks;
  int           n_fail;
  int           act_m[SZ];
  string        cur_name;

  z_to_z_calculator #(.data_size(DS), .size(SZ)) dut (
    .clk(clk),
    .reset(reset),
    .set_diff_act(set_diff_act),
    .start_new_layer(start_new_layer),
    .diff_act(diff_act),
    .diff_cost(diff_cost),
    .diff_dense(diff_dense),
    .diff_z_to_z(diff_z_to_z)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Real-valued Q8.8 multiply: floor(a*b / 256), clamped to 16-bit signed.
  function automatic int ref_mul(input int a, input int b);
    longint p;
    longint q;
    p = longint'(a) * longint'(b);
    q = p / 256;
    if (p < 0 && (p % 256) != 0) q = q - 1;
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return int'(q);
  endfunction

  function automatic int lane_val(input logic [W-1:0] v, input int i);
    logic [DS-1:0] s;
    s = v[DS*i +: DS];
    return int'($signed(s));
  endfunction

  function automatic logic [W-1:0] pack3(input int l0, input int l1, input int l2);
    logic [DS-1:0] a;
    logic [DS-1:0] b;
    logic [DS-1:0] c;
    a = DS'(l0);
    b = DS'(l1);
    c = DS'(l2);
    return {c, b, a};
  endfunction

  // ---------------- driver ----------------
  // Drives one cycle of inputs, pushes the model's expectation, and advances past the edge.
  task automatic drive(input logic set, input logic sel, input logic [W-1:0] act,
                       input logic [W-1:0] cost, input logic [W-1:0] dense, input string nm);
    logic [W-1:0] upv;
    logic [W-1:0] expv;
    int           r[SZ];
    set_diff_act    = set;
    start_new_layer = sel;
    diff_act        = act;
    diff_cost       = cost;
    diff_dense      = dense;
    upv = sel ? cost : dense;
    for (int i = 0; i < SZ; i++) r[i] = ref_mul(act_m[i], lane_val(upv, i));
    expv = pack3(r[0], r[1], r[2]);
    if (set) for (int i = 0; i < SZ; i++) act_m[i] = lane_val(act, i);
    exp_q.push_back(expv);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd_vec();
    return {$urandom(), $urandom()};
  endfunction

  task automatic check_now(input logic [W-1:0] expv, input string nm);
    n_checks++;
    if (diff_z_to_z !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, diff_z_to_z, expv);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [W-1:0] e;
      e = exp_q.pop_front();
      cur_name = name_q.pop_front();
      n_checks++;
      if (diff_z_to_z !== e) begin
        n_fail++;
        $display("FAIL %s: got %h expected %h", cur_name, diff_z_to_z, e);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    for (int i = 0; i < SZ; i++) act_m[i] = 0;
    reset           = 1'b1;
    set_diff_act    = 1'b1;
    start_new_layer = 1'b1;
    diff_act        = rnd_vec();
    diff_cost       = rnd_vec();
    diff_dense      = rnd_vec();
    #1;
    check_now('0, "reset_immediate");
    repeat (2) @(posedge clk);
    #1;
    check_now('0, "reset_held");
    settle();
    reset = 1'b0;
    #1;

    // First edge after release: act_q is still zero.
    drive(1'b0, 1'b1, rnd_vec(), rnd_vec(), rnd_vec(), "post_reset_first");

    // Output layer.
    drive(1'b1, 1'($urandom_range(0, 1)), pack3(16'h0200, 16'h0100, 16'h0080),
          rnd_vec(), rnd_vec(), "load_act");
    drive(1'b0, 1'b1, rnd_vec(), pack3(16'h0300, 16'hFE80, 16'h0400), rnd_vec(), "output_layer");

    // Hidden layer; diff_cost must be ignored.
    drive(1'b0, 1'b0, rnd_vec(), rnd_vec(), pack3(16'hFE00, 16'h0200, 16'h0100), "hidden_layer");
    drive(1'b0, 1'b0, rnd_vec(), 48'h7FFF_7FFF_7FFF, pack3(16'hFE00, 16'h0200, 16'h0100),
          "hidden_ignores_cost");

    // Load ordering: product at the load edge uses the old derivative.
    drive(1'b1, 1'b0, pack3(16'h0100, 16'h0100, 16'h0100), rnd_vec(), rnd_vec(), "order_setup");
    drive(1'b1, 1'b1, pack3(16'h0200, 16'h0200, 16'h0200),
          pack3(16'h0300, 16'h0300, 16'h0300), rnd_vec(), "order_load_edge");
    drive(1'b0, 1'b1, rnd_vec(), pack3(16'h0300, 16'h0300, 16'h0300), rnd_vec(), "order_next_edge");

    // Saturation and floor rounding.
    drive(1'b1, 1'b0, pack3(16'h0200, 16'h0200, 16'hFF00), rnd_vec(), rnd_vec(), "sat_setup");
    drive(1'b0, 1'b0, rnd_vec(), rnd_vec(), pack3(16'h6400, 16'h9C00, 16'h0001), "sat_floor");
    drive(1'b0, 1'b1, rnd_vec(), pack3(16'h9C00, 16'h6400, 16'h00FF), rnd_vec(), "sat_swap");

    // Randomized traffic with source toggling and random loads.
    for (int n = 0; n < 300; n++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rnd_vec(), rnd_vec(), rnd_vec(),
            "random");
    end
    for (int n = 0; n < 20; n++) begin
      drive(1'b0, 1'(n % 2), rnd_vec(), rnd_vec(), rnd_vec(), "toggle_select");
    end

    // Mid-stream reset with a non-zero derivative loaded.
    drive(1'b1, 1'b1, pack3(16'h0100, 16'h0200, 16'hFF00), rnd_vec(), rnd_vec(), "pre_reset_load");
    drive(1'b0, 1'b1, rnd_vec(), pack3(16'h0300, 16'h0300, 16'h0300), rnd_vec(), "pre_reset_value");
    settle();
    reset = 1'b1;
    for (int i = 0; i < SZ; i++) act_m[i] = 0;
    #1;
    check_now('0, "midstream_reset_immediate");
    @(posedge clk);
    #1;
    check_now('0, "midstream_reset_held");
    settle();
    reset = 1'b0;
    #1;
    for (int n = 0; n < 5; n++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), rnd_vec(), rnd_vec(), rnd_vec(), "after_reset_zero");
    end

    settle();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
